// File: rtl/stack_pkg.sv
// Shared definitions for the LIFO stack: default geometry and the
// operation encoding derived from the {push, pop} request pair.
package stack_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 8;

    // One operation per cycle; REPLACE is push and pop together.
    typedef enum logic [1:0] {
        OP_NONE    = 2'b00,
        OP_PUSH    = 2'b01,
        OP_POP     = 2'b10,
        OP_REPLACE = 2'b11
    } stack_op_t;

    // Map the raw request pair onto the operation encoding.
    function automatic stack_op_t decode_op(input logic push, input logic pop);
        stack_op_t op;
        case ({pop, push})
            2'b01:   op = OP_PUSH;
            2'b10:   op = OP_POP;
            2'b11:   op = OP_REPLACE;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/stack_regfile.sv
// Storage for the LIFO: DEPTH x WIDTH register array, one synchronous
// write port and one asynchronous read port. Contents are never reset.
module stack_regfile #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry; the controller only issues in-range addresses.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read so the top of stack is visible without latency.
    assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack.sv
// Parametrised LIFO stack with occupancy count, full/empty flags,
// overflow/underflow pulses, combinational top peek, synchronous clear
// and replace-top on simultaneous push and pop.
module lifo_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic [WIDTH-1:0] data_out_reg;
    logic             data_valid_reg;
    logic             overflow_reg;
    logic             overflow_next;
    logic             underflow_reg;
    logic             underflow_next;
    logic             pop_load;

    logic             we;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    top_addr;
    logic [WIDTH-1:0] rdata;
    stack_op_t        op;

    assign op    = decode_op(push, pop);
    assign empty = (count_reg == '0);
    assign full  = (count_reg == CNT_W'(DEPTH));

    // Read address parks at entry 0 when empty so it never leaves the array.
    assign top_addr = empty ? '0 : AW'(count_reg - 1'b1);

    stack_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (data_in),
        .raddr (top_addr),
        .rdata (rdata)
    );

    // Next-state decode: count, memory write, pop load and error pulses.
    always_comb begin
        count_next     = count_reg;
        we             = 1'b0;
        waddr          = AW'(count_reg);
        pop_load       = 1'b0;
        overflow_next  = 1'b0;
        underflow_next = 1'b0;
        if (clear) begin
            count_next = '0;
        end else begin
            case (op)
                OP_PUSH: begin
                    if (full) begin
                        overflow_next = 1'b1;
                    end else begin
                        we         = 1'b1;
                        count_next = count_reg + 1'b1;
                    end
                end
                OP_POP: begin
                    if (empty) begin
                        underflow_next = 1'b1;
                    end else begin
                        pop_load   = 1'b1;
                        count_next = count_reg - 1'b1;
                    end
                end
                OP_REPLACE: begin
                    we = 1'b1;
                    if (empty) begin
                        // Nothing to pop: the push still lands in entry 0.
                        underflow_next = 1'b1;
                        waddr          = '0;
                        count_next     = CNT_W'(1);
                    end else begin
                        // Old top goes out while the new word overwrites it.
                        pop_load = 1'b1;
                        waddr    = top_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    // State register; reset clears count, output word and all pulses at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg      <= '0;
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
        end else begin
            count_reg      <= count_next;
            data_valid_reg <= pop_load;
            overflow_reg   <= overflow_next;
            underflow_reg  <= underflow_next;
            if (pop_load) begin
                data_out_reg <= rdata;
            end
        end
    end

    assign count      = count_reg;
    assign top        = empty ? '0 : rdata;
    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;
    assign overflow   = overflow_reg;
    assign underflow  = underflow_reg;

endmodule

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack: directed scenarios followed by
// random push/pop/clear traffic, all checked against a queue-based model.
module tb_lifo_stack;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic          push;
    logic          pop;
    logic [W-1:0]  data_in;
    logic [W-1:0]  top;
    logic [W-1:0]  data_out;
    logic          data_valid;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_dout;
    logic         m_dv;
    logic         m_ov;
    logic         m_uf;

    always #5 clk = ~clk;

    lifo_stack #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .push       (push),
        .pop        (pop),
        .data_in    (data_in),
        .top        (top),
        .data_out   (data_out),
        .data_valid (data_valid),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_dout = '0;
        m_dv   = 1'b0;
        m_ov   = 1'b0;
        m_uf   = 1'b0;
    endtask

    // Apply the behavioural rules for one clock edge.
    task automatic model_step(input logic c, input logic pu, input logic po, input logic [W-1:0] d);
        m_dv = 1'b0;
        m_ov = 1'b0;
        m_uf = 1'b0;
        if (c) begin
            m_q.delete();
        end else if (pu && po) begin
            if (m_q.size() == 0) begin
                m_q.push_back(d);
                m_uf = 1'b1;
            end else begin
                m_dout = m_q[m_q.size() - 1];
                m_dv   = 1'b1;
                m_q[m_q.size() - 1] = d;
            end
        end else if (pu) begin
            if (m_q.size() == D) m_ov = 1'b1;
            else m_q.push_back(d);
        end else if (po) begin
            if (m_q.size() == 0) m_uf = 1'b1;
            else begin
                m_dout = m_q.pop_back();
                m_dv   = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [W-1:0] exp_top;
        exp_top = (m_q.size() == 0) ? '0 : m_q[m_q.size() - 1];
        check_eq({tag, ".count"}, 32'(count), 32'(m_q.size()));
        check_eq({tag, ".empty"}, 32'(empty), 32'(m_q.size() == 0));
        check_eq({tag, ".full"}, 32'(full), 32'(m_q.size() == D));
        check_eq({tag, ".top"}, 32'(top), 32'(exp_top));
        check_eq({tag, ".data_out"}, 32'(data_out), 32'(m_dout));
        check_eq({tag, ".data_valid"}, 32'(data_valid), 32'(m_dv));
        check_eq({tag, ".overflow"}, 32'(overflow), 32'(m_ov));
        check_eq({tag, ".underflow"}, 32'(underflow), 32'(m_uf));
    endtask

    // One transaction: drive inputs, take an edge, compare #1 after it.
    task automatic cycle(input string tag, input logic c, input logic pu, input logic po, input logic [W-1:0] d);
        clear   = c;
        push    = pu;
        pop     = po;
        data_in = d;
        @(posedge clk);
        #1;
        model_step(c, pu, po, d);
        check_all(tag);
        $display("%s clr=%0b push=%0b pop=%0b din=%02h -> count=%0d top=%02h dout=%02h dv=%0b ov=%0b uf=%0b",
                 tag, c, pu, po, d, count, top, data_out, data_valid, overflow, underflow);
        clear = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        clear   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_all("reset");
        cycle("idle", 0, 0, 0, 8'h00);

        // Basic LIFO order
        cycle("push11", 0, 1, 0, 8'h11);
        cycle("push22", 0, 1, 0, 8'h22);
        cycle("push33", 0, 1, 0, 8'h33);
        for (int i = 0; i < 3; i++) cycle("pop", 0, 0, 1, 8'h00);

        // Fill, overflow, pop returns last accepted word
        for (int i = 0; i < D; i++) cycle("fill", 0, 1, 0, 8'(8'h40 + i));
        cycle("push_full", 0, 1, 0, 8'hAA);
        cycle("pop_after_ovf", 0, 0, 1, 8'h00);
        cycle("clear", 1, 0, 0, 8'h00);

        // Underflow cases
        cycle("pop_empty", 0, 0, 1, 8'h00);
        cycle("pushpop_empty", 0, 1, 1, 8'h5C);
        cycle("clear2", 1, 0, 0, 8'h00);

        // Replace-top, then replace while full
        cycle("push01", 0, 1, 0, 8'h01);
        cycle("push02", 0, 1, 0, 8'h02);
        cycle("replace77", 0, 1, 1, 8'h77);
        for (int i = 0; i < D - 2; i++) cycle("fill2", 0, 1, 0, 8'(8'h80 + i));
        cycle("replace_full", 0, 1, 1, 8'hE1);
        cycle("replace_full2", 0, 1, 1, 8'hE2);

        // Clear has priority over push
        cycle("clear3", 1, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) cycle("push3", 0, 1, 0, 8'(8'hC0 + i));
        cycle("clear_push", 1, 1, 0, 8'hDD);
        cycle("idle2", 0, 0, 0, 8'h00);

        // Asynchronous reset during a pop, checked before the next edge
        cycle("pre_rst_a", 0, 1, 0, 8'h9A);
        cycle("pre_rst_b", 0, 1, 0, 8'h9B);
        cycle("pre_rst_pop", 0, 0, 1, 8'h00);
        pop = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        $display("async_rst mid-pop -> count=%0d dout=%02h dv=%0b", count, data_out, data_valid);
        @(posedge clk);
        #1;
        pop   = 1'b0;
        reset = 1'b0;
        check_all("async_rst_rel");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            logic c, pu, po;
            r  = int'($urandom_range(0, 99));
            c  = (r < 4);
            pu = ($urandom_range(0, 99) < 55);
            po = ($urandom_range(0, 99) < 45);
            cycle("rand", c, pu, po, 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
